// File: rtl/mipi_pkg.sv
// Shared MIPI RX definitions: packet data types and the payload qualifier state encoding.
package mipi_pkg;

   localparam logic [5:0] DT_FS       = 6'h00;
   localparam logic [5:0] DT_FE       = 6'h01;
   localparam logic [5:0] DT_RGB888   = 6'h3E;
   localparam logic [5:0] DT_LONG_MIN = 6'h10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PAYLOAD = 2'd1,
      DROP    = 2'd2
   } rx_state_t;

   function automatic logic is_short_dt(input logic [5:0] dt);
      return dt < DT_LONG_MIN;
   endfunction

endpackage

// File: rtl/mipi_rx_fifo_writen_gen.sv
// Qualifies RX long-packet payload beats into registered line-FIFO writes and
// tracks frame/line boundaries plus sticky length and overflow errors.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a header; stray payload beats flag Length_err
//   PAYLOAD | target packet in flight, each beat becomes a FIFO write
//   DROP    | non-target long packet, beats are counted but discarded
module mipi_rx_fifo_writen_gen
   import mipi_pkg::*;
#(
   parameter int         BYTES_PER_BEAT = 4,
   parameter int         DATA_W         = 32,
   parameter logic [5:0] TARGET_DT      = DT_RGB888
) (
   input  logic              CLK_rx,
   input  logic              RSTn,
   input  logic              Rx_hdr_valid,
   input  logic [5:0]        Rx_hdr_data_type,
   input  logic [15:0]       Rx_hdr_word_count,
   input  logic              Rx_payload_valid,
   input  logic [DATA_W-1:0] Rx_payload_data,
   input  logic              Fifo_full,
   input  logic              Err_clr,
   output logic              Fifo_writen,
   output logic [DATA_W-1:0] Fifo_wdata,
   output logic              Fifo_wlast,
   output logic              Frame_start,
   output logic              Frame_end,
   output logic              Line_done,
   output logic [11:0]       Line_count,
   output logic              Length_err,
   output logic              Overflow_err
);

   localparam logic [15:0] BPB = 16'(BYTES_PER_BEAT);

   rx_state_t   state;
   logic [15:0] remaining;
   logic        last_beat;
   logic [15:0] dec;
   logic        beat_in_pkt;
   logic        len_err_set;
   logic        ovf_set;
   logic        hdr_long;

   always_comb begin
      last_beat   = remaining <= BPB;
      dec         = last_beat ? remaining : BPB;
      beat_in_pkt = !Rx_hdr_valid && Rx_payload_valid && (state != IDLE);
      hdr_long    = !is_short_dt(Rx_hdr_data_type) && (Rx_hdr_word_count != 16'd0);
      len_err_set = (Rx_hdr_valid && (state != IDLE)) ||
                    (!Rx_hdr_valid && Rx_payload_valid && (state == IDLE));
      ovf_set     = beat_in_pkt && (state == PAYLOAD) && Fifo_full;
   end

   always_ff @(posedge CLK_rx or negedge RSTn) begin
      if (!RSTn) begin
         state        <= IDLE;
         remaining    <= '0;
         Fifo_writen  <= 1'b0;
         Fifo_wdata   <= '0;
         Fifo_wlast   <= 1'b0;
         Frame_start  <= 1'b0;
         Frame_end    <= 1'b0;
         Line_done    <= 1'b0;
         Line_count   <= '0;
         Length_err   <= 1'b0;
         Overflow_err <= 1'b0;
      end else begin
         Fifo_writen <= 1'b0;
         Fifo_wlast  <= 1'b0;
         Frame_start <= 1'b0;
         Frame_end   <= 1'b0;
         Line_done   <= 1'b0;

         // A header always wins: any packet in flight is abandoned without wlast/Line_done.
         if (Rx_hdr_valid) begin
            state     <= IDLE;
            remaining <= '0;
            if (is_short_dt(Rx_hdr_data_type)) begin
               if (Rx_hdr_data_type == DT_FS) begin
                  Frame_start <= 1'b1;
                  Line_count  <= '0;
               end
               if (Rx_hdr_data_type == DT_FE) begin
                  Frame_end <= 1'b1;
               end
            end else if (hdr_long) begin
               remaining <= Rx_hdr_word_count;
               state     <= (Rx_hdr_data_type == TARGET_DT) ? PAYLOAD : DROP;
            end
         end else if (beat_in_pkt) begin
            remaining <= remaining - dec;
            if (last_beat) begin
               state <= IDLE;
            end
            if (state == PAYLOAD) begin
               Fifo_wdata  <= Rx_payload_data;
               Fifo_writen <= !Fifo_full;
               Fifo_wlast  <= last_beat && !Fifo_full;
               Line_done   <= last_beat;
               if (last_beat && (Line_count != 12'hFFF)) begin
                  Line_count <= Line_count + 12'd1;
               end
            end
         end

         if (len_err_set) begin
            Length_err <= 1'b1;
         end else if (Err_clr) begin
            Length_err <= 1'b0;
         end

         if (ovf_set) begin
            Overflow_err <= 1'b1;
         end else if (Err_clr) begin
            Overflow_err <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mipi_rx_fifo_writen_gen.md
# mipi_rx_fifo_writen_gen

Receive-side companion to the TX FIFO read-enable logic. It sits between the MIPI RX controller's packet interface and the pixel line FIFO, on the `CLK_rx` domain. It qualifies payload beats of RGB888 long packets (data type 3Eh) by header and word count, and issues registered FIFO write strobes. It also tracks frame/line boundaries from short packets and flags length and overflow errors.

## Interface
Parameters:
- `BYTES_PER_BEAT`, default 4: payload bytes per `Rx_payload_data` beat (power of two, 1..8).
- `DATA_W`, default 32: must equal 8*`BYTES_PER_BEAT`.
- `TARGET_DT`, default 6'h3E: long-packet data type forwarded to the FIFO.

Ports:
- `CLK_rx` in 1: receive byte/word clock; the only clock.
- `RSTn` in 1: reset, asynchronous, active-low.
- `Rx_hdr_valid` in 1: one-cycle pulse, packet header valid.
- `Rx_hdr_data_type` in 6: header data type; sampled with `Rx_hdr_valid`.
- `Rx_hdr_word_count` in 16: long-packet byte count; sampled with `Rx_hdr_valid`.
- `Rx_payload_valid` in 1: payload beat valid.
- `Rx_payload_data` in `DATA_W`: payload beat, byte 0 in bits [7:0].
- `Fifo_full` in 1: FIFO cannot accept a write this cycle.
- `Err_clr` in 1: clears the sticky error flags.
- `Fifo_writen` out 1: FIFO write strobe (registered).
- `Fifo_wdata` out `DATA_W`: write data, aligned with `Fifo_writen`.
- `Fifo_wlast` out 1: marks the last write of a line, aligned with `Fifo_writen`.
- `Frame_start` out 1: one-cycle pulse on FS short packet (00h).
- `Frame_end` out 1: one-cycle pulse on FE short packet (01h).
- `Line_done` out 1: one-cycle pulse when a target packet completes.
- `Line_count` out 12: completed target lines since the last FS.
- `Length_err` out 1: sticky packet length / sequencing error.
- `Overflow_err` out 1: sticky; a write was dropped because of `Fifo_full`.

## Operation
- State `IDLE`, on `Rx_hdr_valid`:
  - Data type < 10h (short packet): 00h pulses `Frame_start` and clears `Line_count`; 01h pulses `Frame_end`; any other short type is ignored. Stay in `IDLE`.
  - Data type == `TARGET_DT` and word count != 0: load `remaining` = word count, go to `PAYLOAD`.
  - Any other long type with word count != 0: load `remaining`, go to `DROP`.
  - Word count == 0: stay in `IDLE`; no write, no `Line_done`.
- `PAYLOAD`, each `Rx_payload_valid` beat:
  - Capture the data and request a write.
  - `remaining` -= min(`BYTES_PER_BEAT`, `remaining`).
  - If `remaining` <= `BYTES_PER_BEAT` before the decrement, this is the last beat: set `wlast`, pulse `Line_done`, increment `Line_count` (saturates at 4095), go to `IDLE`.
  - A partial last beat is written whole; the unused bytes are don't-care.
- `DROP`: same counting as `PAYLOAD`, no writes, no `Line_done`; returns to `IDLE` on the last beat.
- `Rx_hdr_valid` while in `PAYLOAD` or `DROP`:
  - Set `Length_err` and abandon the current packet.
  - No `Line_done`, and no `Fifo_wlast` for the truncated line.
  - Process the new header exactly as from `IDLE` in the same cycle.
- `Rx_payload_valid` in `IDLE`: beat ignored, `Length_err` set.
- Write request with `Fifo_full`=1: the write is suppressed (`Fifo_writen`=0), `Overflow_err` set, and counting continues normally.
- `Err_clr` clears both flags. A new error in the same cycle wins, so the flag stays set.
- `remaining` is 16-bit unsigned; the subtraction never underflows.

## Timing
- Reset values:
  - All outputs 0, including `Line_count`, both error flags and `Fifo_wdata`.
  - State `IDLE`, `remaining` = 0.
- Write latency: `Fifo_writen`, `Fifo_wdata` and `Fifo_wlast` are asserted in the cycle after the qualifying payload beat.
- `Line_done` is registered and coincides with the `Fifo_wlast` write, even if that write was dropped.
- `Frame_start` and `Frame_end` go high the cycle after `Rx_hdr_valid`.
- `Fifo_full` is sampled in the same cycle as the payload beat.
- The header and the first payload beat never share a cycle. Payload may start the cycle after the header.
- Back-to-back beats are supported at one per cycle with no bubbles.
- `RSTn` asserted mid-packet: outputs clear immediately (asynchronously); after release the block waits in `IDLE` for the next header.

## Structure
- Shared package (`mipi_pkg`):
  - Data type constants: `DT_FS`=6'h00, `DT_FE`=6'h01, `DT_RGB888`=6'h3E, `DT_LONG_MIN`=6'h10.
  - State enum: `IDLE`/`PAYLOAD`/`DROP`.
- Single module, no sub-modules. The byte counter is inline.

## Test plan
- FS, then a 3Eh header with WC=5760 and 1440 continuous beats, then FE:
  - 1440 `Fifo_writen` pulses, each one cycle after its beat.
  - `Fifo_wlast` and `Line_done` on the last write.
  - `Line_count`=1; `Frame_start`/`Frame_end` pulse once each.
- 2Bh header, WC=16, 4 beats: zero writes, no `Line_done`, no errors; the next 3Eh packet is written normally.
- 3Eh, WC=6: 2 writes, `Fifo_wlast` on the 2nd, `remaining` reaches 0, state returns to `IDLE`.
- 3Eh, WC=16, new 3Eh header after 2 beats:
  - `Length_err`=1, no `Line_done` for the first packet.
  - The second packet's 4 beats are written with `wlast` on its 4th.
- `Fifo_full` held during beats 3–4 of an 8-beat line:
  - 6 writes, `Overflow_err`=1, `Line_done` still pulses.
  - `Err_clr` then clears the flag; `Err_clr` together with a new overflow keeps it at 1.
- `RSTn` pulsed mid-payload: all outputs 0; stray beats after reset set `Length_err`; the next FS plus line works normally.
